aplic_regif_width_adapter: RTL
==============================

Name: aplic_regif_width_adapter

Overview:
- Bridges a flat, width-parametrised register port (DATA_W = 32 or 64) onto the 32-bit reg_intf config port of aplic_top.
- Splits 64-bit accesses into sequenced 32-bit beats and merges read data.
- Enforces a per-beat downstream timeout.
- Sits between the SoC register crossbar and aplic_top, replacing the plain flat-port adapter.

Parameters:
- DATA_W, 64, upstream data width; legal values 32 or 64.
- ADDR_W, 32, upstream address width; downstream address is always 32 bits, zero-extended or truncated.
- TIMEOUT, 16, maximum cycles a downstream beat may wait for dn_ready; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- ni_rst  in  1  asynchronous active-low reset
- up_addr  in  ADDR_W  upstream byte address
- up_write  in  1  1 = write, 0 = read
- up_wdata  in  DATA_W  write data
- up_wstrb  in  DATA_W/8  byte strobes
- up_valid  in  1  request valid; held stable until up_ready
- up_rdata  out  DATA_W  read data, valid with up_ready
- up_error  out  1  error, valid with up_ready
- up_ready  out  1  single-cycle completion pulse
- dn_addr  out  32  downstream reg_intf a32_d32 address
- dn_write  out  1  downstream write
- dn_wdata  out  32  downstream write data
- dn_wstrb  out  4  downstream strobes
- dn_valid  out  1  downstream valid
- dn_rdata  in  32  downstream read data
- dn_error  in  1  downstream error
- dn_ready  in  1  downstream completion

Behaviour:
- One clock, i_clk; reset ni_rst is asynchronous, active-low. On reset every output is 0 and the FSM is in IDLE.
- Handshake (both sides, reg_intf style): valid is held with stable fields until ready; ready is a single-cycle pulse carrying rdata and error.
- FSM: IDLE -> ISSUE -> RESP -> IDLE. Two internal beat slots: beat0 = low word, beat1 = high word (64-bit only).
- IDLE, on up_valid:
  - Latch addr, write, wdata and wstrb.
  - Base address = up_addr with bits [log2(DATA_W/8)-1:0] cleared.
  - Beat0 addr = base; beat1 addr = base + 4.
  - Reads issue all beats.
  - Writes issue only beats whose 4-bit strobe slice is nonzero.
  - If no beat is needed (write, wstrb all zero): go to RESP with error = 0.
  - If up_addr is not aligned to DATA_W/8: go to RESP with error = 1, rdata = 0, no downstream traffic.
  - Otherwise go to ISSUE at the first needed beat.
- ISSUE:
  - dn_valid = 1, driving the current beat's fields.
  - Timer clears on beat entry and increments each cycle dn_ready = 0.
  - On dn_ready: store dn_rdata into its half of the read buffer, OR dn_error into a sticky error flag, then advance to the next needed beat or to RESP. dn_valid stays high across back-to-back beats.
  - Timeout: if TIMEOUT != 0 and the timer reaches TIMEOUT - 1 without dn_ready, drop dn_valid, set the error flag, skip remaining beats and go to RESP.
  - Read halves not completed return 0.
- RESP: up_ready = 1 for one cycle, driving up_rdata and up_error, then go to IDLE. A new request is sampled no earlier than the cycle after RESP.
- Latency with dn_ready arriving in the first ISSUE cycle:
  - 1 beat: up_ready 2 cycles after up_valid is sampled.
  - 2 beats: 3 cycles.
- up_valid deasserting mid-transaction is a protocol violation; the transaction completes regardless.
- Reset asserted mid-operation: dn_valid and up_ready drop asynchronously, the read buffer and error flag clear, and no response is emitted.
- DATA_W = 32: beat1 logic is absent and behaviour is pure pass-through with registered timing.

Optional Feature:
- Macro: APLIC_REGIF_ERRCNT_EN.
- With the macro: extra output o_err_cnt [15:0].
  - Increments by 1 on every RESP with up_error = 1 (alignment, downstream error or timeout).
  - Saturates at 0xFFFF.
  - Reset value 0.
- Without the macro: no port, no counter logic.

Decomposition:
- Package aplic_regif_pkg:
  - state enum (IDLE, ISSUE, RESP)
  - beat index type
  - BEAT_W = 32 constant
  - function returning the timer width from TIMEOUT
  - a typedef for the latched request struct
- One natural sub-module, aplic_regif_timeout: a counter with clear/enable inputs and an expired output, parametrised by TIMEOUT.

Test Plan:
- 64-bit read at 0x0000_4000, downstream returns 0x1111_1111 then 0x2222_2222 with immediate dn_ready -> two dn beats at 0x4000 and 0x4004; up_rdata = 0x2222_2222_1111_1111, up_error = 0, up_ready 3 cycles after up_valid.
- 64-bit write at 0x0000_3000 with wstrb = 0xF0 and wdata = 0xAABB_CCDD_0000_0000 -> single dn beat, addr 0x3004, wdata 0xAABB_CCDD, wstrb 0xF; up_error = 0.
- Write with wstrb = 0x00 -> no dn_valid; up_ready 1 cycle after sampling; error = 0.
- Read at 0x0000_2004 with DATA_W = 64 -> no downstream traffic; up_error = 1; up_rdata = 0.
- TIMEOUT = 16, dn_ready held low -> dn_valid high exactly 16 cycles then low; up_error = 1; with APLIC_REGIF_ERRCNT_EN, o_err_cnt goes 0 -> 1.
- Reset pulse during beat1 of a 64-bit read -> dn_valid falls asynchronously, no up_ready pulse, and the next read completes normally.

Source files
------------

// File: rtl/aplic_regif_pkg.sv
// -----------------------------------------------------------------------------
// aplic_regif_pkg
// Shared types and constants for the APLIC register-port width adapter.
//   state_e     : adapter FSM states (IDLE -> ISSUE -> RESP -> IDLE)
//   beat_idx_t  : downstream beat index (0 = low word, 1 = high word)
//   BEAT_W      : downstream data width (reg_intf a32_d32)
//   req_t       : latched upstream request, sized for the widest (64-bit) port
//   timer_width : counter width needed to count 0 .. TIMEOUT-1
// -----------------------------------------------------------------------------
package aplic_regif_pkg;

  localparam int BEAT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef logic beat_idx_t;

  // addr holds the already-aligned 32-bit base address.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  // The counter only has to reach TIMEOUT-1; keep at least one bit so the
  // declaration stays legal when the timeout is disabled or trivially small.
  function automatic int timer_width(input int timeout);
    if (timeout <= 2) return 1;
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/aplic_regif_timeout.sv
// -----------------------------------------------------------------------------
// aplic_regif_timeout
// Per-beat wait counter. Counts cycles while en_i is high, restarts from zero
// whenever clr_i is high, and flags expired_o in the cycle where the count has
// reached TIMEOUT-1 and the beat is still waiting. TIMEOUT = 0 disables it.
// Ports:
//   i_clk      clock
//   ni_rst     asynchronous active-low reset
//   clr_i      restart count (beat entry / not issuing)
//   en_i       beat is waiting this cycle (dn_valid && !dn_ready)
//   expired_o  wait limit reached this cycle
// -----------------------------------------------------------------------------
module aplic_regif_timeout
  import aplic_regif_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic ni_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = timer_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired_o = 1'b0;
    end else begin : g_on
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Gated by en_i so a ready in the final cycle still wins over expiry.
      assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/aplic_regif_width_adapter.sv
// -----------------------------------------------------------------------------
// aplic_regif_width_adapter
// Bridges a flat DATA_W (32/64) register port onto the 32-bit reg_intf config
// port of aplic_top. 64-bit accesses are split into a low beat (base) and a
// high beat (base + 4); write beats with an all-zero strobe slice are skipped.
// Misaligned requests are answered with an error and no downstream traffic.
// Each downstream beat is bounded by TIMEOUT cycles (0 = unbounded).
//
// Optional feature (macro APLIC_REGIF_ERRCNT_EN): adds o_err_cnt[15:0], a
// saturating count of error responses.
//
// Ports:
//   i_clk, ni_rst                 clock, asynchronous active-low reset
//   up_addr/write/wdata/wstrb     upstream request fields, held with up_valid
//   up_valid                      upstream request valid
//   up_rdata/up_error/up_ready    upstream response, up_ready is a 1-cycle pulse
//   dn_addr/write/wdata/wstrb     downstream beat fields, valid with dn_valid
//   dn_valid                      downstream request valid
//   dn_rdata/dn_error/dn_ready    downstream response, dn_ready is a 1-cycle pulse
//   o_err_cnt                     error response count (APLIC_REGIF_ERRCNT_EN only)
// -----------------------------------------------------------------------------
module aplic_regif_width_adapter
  import aplic_regif_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                ni_rst,
  input  logic [ADDR_W-1:0]   up_addr,
  input  logic                up_write,
  input  logic [DATA_W-1:0]   up_wdata,
  input  logic [DATA_W/8-1:0] up_wstrb,
  input  logic                up_valid,
  output logic [DATA_W-1:0]   up_rdata,
  output logic                up_error,
  output logic                up_ready,
  output logic [31:0]         dn_addr,
  output logic                dn_write,
  output logic [31:0]         dn_wdata,
  output logic [3:0]          dn_wstrb,
  output logic                dn_valid,
  input  logic [31:0]         dn_rdata,
  input  logic                dn_error,
  input  logic                dn_ready
`ifdef APLIC_REGIF_ERRCNT_EN
  ,
  output logic [15:0]         o_err_cnt
`endif
);

  localparam int NB     = DATA_W / BEAT_W;   // beats per upstream access
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);    // address bits below the access size

  state_e      state_q, state_d;
  beat_idx_t   beat_q, beat_d;
  req_t        req_q, req_d;
  logic [63:0] rbuf_q, rbuf_d;
  logic        err_q, err_d;

  logic [31:0] up_addr32;
  logic [31:0] up_base;
  logic [63:0] up_wdata64;
  logic [7:0]  up_wstrb8;
  logic        up_misaligned;
  logic        up_need0, up_need1;
  logic        req_need1;
  logic        tmr_en, tmr_expired;

  // Normalise the upstream fields to the fixed 32/64/8-bit request layout.
  // With DATA_W = 32 the upper halves are constant zero and beat1 folds away.
  assign up_addr32     = 32'(up_addr);
  assign up_base       = up_addr32 & ~32'(STRB_W - 1);
  assign up_wdata64    = 64'(up_wdata);
  assign up_wstrb8     = 8'(up_wstrb);
  assign up_misaligned = |up_addr[OFF_W-1:0];

  // Reads always need every beat; writes only the beats with live strobes.
  assign up_need0  = !up_write || (|up_wstrb8[3:0]);
  assign up_need1  = (NB == 2) && (!up_write || (|up_wstrb8[7:4]));
  assign req_need1 = (NB == 2) && (!req_q.write || (|req_q.wstrb[7:4]));

  // Timer runs only while a beat is outstanding; any other cycle restarts it,
  // so it reads zero on the first cycle of every beat.
  assign tmr_en = (state_q == ISSUE) && !dn_ready;

  aplic_regif_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .ni_rst    (ni_rst),
    .clr_i     (!tmr_en),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    req_d   = req_q;
    rbuf_d  = rbuf_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (up_valid) begin
          req_d.addr  = up_base;
          req_d.write = up_write;
          req_d.wdata = up_wdata64;
          req_d.wstrb = up_wstrb8;
          rbuf_d      = '0;
          err_d       = up_misaligned;
          if (up_misaligned || (!up_need0 && !up_need1)) begin
            state_d = RESP;
          end else begin
            state_d = ISSUE;
            beat_d  = up_need0 ? 1'b0 : 1'b1;
          end
        end
      end

      ISSUE: begin
        if (dn_ready) begin
          if (beat_q) begin
            rbuf_d[63:32] = dn_rdata;
          end else begin
            rbuf_d[31:0] = dn_rdata;
          end
          err_d = err_q | dn_error;
          // Staying in ISSUE keeps dn_valid high straight into the next beat.
          if (!beat_q && req_need1) begin
            beat_d = 1'b1;
          end else begin
            state_d = RESP;
          end
        end else if (tmr_expired) begin
          // Abandon the remaining beats; unfinished read halves stay zero.
          err_d   = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state_q <= IDLE;
      beat_q  <= 1'b0;
      req_q   <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
      rbuf_q  <= rbuf_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from registered state only and forced to zero outside
  // their valid phase, so reset clears them immediately.
  assign dn_valid = (state_q == ISSUE);
  assign dn_addr  = dn_valid ? (req_q.addr + {29'd0, beat_q, 2'b00}) : '0;
  assign dn_write = dn_valid && req_q.write;
  assign dn_wdata = !dn_valid ? '0 : (beat_q ? req_q.wdata[63:32] : req_q.wdata[31:0]);
  assign dn_wstrb = !dn_valid ? '0 : (beat_q ? req_q.wstrb[7:4]   : req_q.wstrb[3:0]);

  assign up_ready = (state_q == RESP);
  assign up_error = up_ready && err_q;
  assign up_rdata = up_ready ? rbuf_q[DATA_W-1:0] : '0;

`ifdef APLIC_REGIF_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (up_error && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`endif

endmodule
